// File: rtl/picorv_mem_arbiter_if.sv
// One PicoRV32 native memory port. The master side issues requests and the
// slave side completes them with ready/rdata.
interface picorv_mem_arbiter_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv_mem_arbiter.sv
// Two-requester arbiter for a shared PicoRV32 native memory port. It inserts a
// forced idle cycle between transactions so the downstream adapter sees each boundary.
module picorv_mem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  picorv_mem_arbiter_if.slave         s0,
  picorv_mem_arbiter_if.slave         s1,
  picorv_mem_arbiter_if.master        m,
  output logic [1:0]                  grant,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_last;
  logic [1:0]  r_grant;
  logic        r_busy;

  logic        w_active;
  logic        w_ownerValid;
  logic        w_anyReq;
  logic        w_pick;

  assign w_active     = (r_state == ACTIVE);
  assign w_ownerValid = r_owner ? s1.mem_valid : s0.mem_valid;
  assign w_anyReq     = s0.mem_valid | s1.mem_valid;

  // On a tie, round-robin hands the port to whoever was not granted last.
  assign w_pick = (s0.mem_valid && s1.mem_valid)
                ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last)
                : s1.mem_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A requester abandoning its request is treated like a completion.
          if (m.mem_ready || !w_ownerValid) begin
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m.mem_valid = w_active & w_ownerValid;
  assign m.mem_instr = w_active & (r_owner ? s1.mem_instr : s0.mem_instr);
  assign m.mem_addr  = w_active ? (r_owner ? s1.mem_addr  : s0.mem_addr)  : 32'h0;
  assign m.mem_wdata = w_active ? (r_owner ? s1.mem_wdata : s0.mem_wdata) : 32'h0;
  assign m.mem_wstrb = w_active ? (r_owner ? s1.mem_wstrb : s0.mem_wstrb) : 4'h0;

  assign s0.mem_ready = w_active & ~r_owner & m.mem_ready;
  assign s1.mem_ready = w_active &  r_owner & m.mem_ready;
  assign s0.mem_rdata = m.mem_rdata;
  assign s1.mem_rdata = m.mem_rdata;

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

// File: doc/picorv_mem_arbiter.md
# picorv_mem_arbiter

Two-requester arbiter that shares one PicoRV32 native memory port between two masters, such as a core's instruction and data paths or two cores, ahead of the PicoRV32-to-FreeAHB adapter. It grants one requester at a time and holds the grant until the downstream `mem_ready`. Between transactions it forces a downstream `mem_valid` low cycle, so the adapter sees every transaction boundary. Arbitration is round-robin by default, with an optional fixed-priority mode.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = requester 0 always wins ties.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s0_mem_valid`, `s1_mem_valid`  in  1  requester transaction request; held until that requester's ready.
- `s0_mem_instr`, `s1_mem_instr`  in  1  instruction-fetch flag.
- `s0_mem_addr`, `s1_mem_addr`  in  32  byte address.
- `s0_mem_wdata`, `s1_mem_wdata`  in  32  write data.
- `s0_mem_wstrb`, `s1_mem_wstrb`  in  4  byte strobes; 0000 = read.
- `s0_mem_ready`, `s1_mem_ready`  out  1  transaction-complete pulse to requester.
- `s0_mem_rdata`, `s1_mem_rdata`  out  32  read data; both are a copy of `m_mem_rdata`.
- `m_mem_valid`  out  1  downstream request.
- `m_mem_instr`, `m_mem_addr`, `m_mem_wdata`, `m_mem_wstrb`  out  1/32/32/4  downstream request fields.
- `m_mem_ready`  in  1  downstream completion.
- `m_mem_rdata`  in  32  downstream read data.
- `grant`  out  2  one-hot current owner; bit0 = s0, bit1 = s1.
- `busy`  out  1  high in ACTIVE and RELEASE.

## Operation
- FSM states: IDLE, ACTIVE, RELEASE. A registered `owner` bit records the current owner; a registered `last` bit records the most recently granted requester.
- **IDLE**
  - No valid request: stay in IDLE.
  - Exactly one valid request: grant it.
  - Both valid with `FIXED_PRIO`=0: grant `!last`.
  - Both valid with `FIXED_PRIO`=1: grant s0.
  - On any grant, load `owner` and `last`, then go to ACTIVE.
- **ACTIVE**
  - `m_mem_valid` = `s<owner>_mem_valid`.
  - `m_mem_instr/addr/wdata/wstrb` are muxed combinationally from the owner.
  - `s<owner>_mem_ready` = `m_mem_ready`; the non-owner's ready is 0.
  - On `m_mem_ready`=1, go to RELEASE.
  - If the owner drops valid without ready (protocol abort), go to RELEASE.
- **RELEASE**
  - `m_mem_valid`=0 and both readies are 0, for exactly one cycle; then go to IDLE.
  - No arbitration happens in RELEASE.
- Outside ACTIVE:
  - `m_mem_valid`=0, `m_mem_wstrb`=0, `m_mem_addr`=0, `m_mem_wdata`=0, `m_mem_instr`=0.
  - `m_mem_ready` is ignored and never forwarded.
- The non-owner's request is never dropped. It stays pending and is considered at the next IDLE.
- `grant` = one-hot(`owner`) in ACTIVE and RELEASE; 00 in IDLE.
- Reset, including assertion mid-transaction:
  - State returns to IDLE and `last` returns to 1, so s0 wins the first tie in round-robin mode.
  - `grant`=00, `busy`=0, `m_mem_valid`=0, both `sX_mem_ready`=0.
  - Any in-flight downstream transaction is abandoned; the adapter sees `m_mem_valid` low.

## Timing
- Grant latency: request sampled in IDLE at edge N; `m_mem_valid`=1 during cycle N+1 (ACTIVE).
- Completion: `m_mem_ready` in cycle M is forwarded to the owner in the same cycle M (zero added latency). RELEASE is cycle M+1; IDLE is M+2.
- Minimum back-to-back spacing: a new downstream `m_mem_valid` can rise no earlier than cycle M+3 (three cycles after ready).
- No combinational path from `m_mem_ready` to `m_mem_valid`. Ready-to-ready paths are combinational through the `owner` mux only.
- `m_mem_ready` asserted in the first ACTIVE cycle is legal and completes the transaction in that cycle.

## Test plan
- **Single read, s0.** Drive s0 valid, addr=0x100, wstrb=0. Downstream ready one cycle after `m_mem_valid` with rdata=0xDEADBEEF. Required:
  - `m_mem_addr`=0x100.
  - `s0_mem_ready` pulses once with `s0_mem_rdata`=0xDEADBEEF.
  - `s1_mem_ready` stays 0.
  - `m_mem_valid` is low in the following cycle.
- **Simultaneous requests, round-robin.**
  - First pass: after reset, s0 (addr 0x10) and s1 (addr 0x20) raise valid together. Grants go s0 then s1, each separated by a RELEASE cycle with `m_mem_valid`=0.
  - Second pass: repeat with both again → s0 is served before s1, because `last`=1 after the s1 grant.
- **Simultaneous requests, `FIXED_PRIO`=1.** s0 re-requests every cycle after its ready, and s1 is held valid. Required: s1 never granted while s0 is valid in IDLE; `grant` alternates 01/00 only.
- **Write routing.**
  - s1 write, addr=0x2000_0004, wdata=0x11223344, wstrb=0101.
  - Required: `m_mem_wstrb`=0101, `m_mem_wdata`=0x11223344, `m_mem_addr`=0x2000_0004.
  - Ready with a 5-cycle downstream delay → `s1_mem_ready` is high only in the cycle of `m_mem_ready`.
- **Reset mid-transaction.** Assert `reset` in the 2nd ACTIVE cycle of an s1 read. Required:
  - Next cycle: all outputs at reset values.
  - A stale `m_mem_ready` in that cycle is not forwarded.
  - A subsequent s0 request is granted normally.
- **Owner abort.** s0 drops valid in ACTIVE without ready. Required: RELEASE next cycle, then IDLE; a pending s1 is granted at the following IDLE edge.
